// File: rtl/pipe_pkg.sv
// pipe_pkg: definitions shared by the pipeline stage register and its entry
// flops.
//   OCC_W   - width of the occupancy count (0, 1 or 2 entries)
//   state_e - stage state; each encoding equals the number of held entries
package pipe_pkg;

    localparam int OCC_W = 2;

    typedef enum logic [OCC_W-1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_entry_reg.sv
// pipe_entry_reg: one payload entry, made of a WIDTH-bit data flop and a
// valid flop.
//   clk, rst     - clock; synchronous active-high reset (clears valid only)
//   load, d      - capture d and mark the entry valid
//   clear        - mark the entry empty; wins over load
//   q, valid     - held payload and its valid flag
// The data flop has no reset: its contents are don't-care while valid is 0.
module pipe_entry_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             valid
);

    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d, data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign q     = data_q;
    assign valid = valid_q;

endmodule

// File: rtl/pipeline_skid_stage.sv
// pipeline_skid_stage: a valid/ready pipeline register between two stages.
// It has an optional two-entry skid buffer, a synchronous flush and a
// saturating stall counter.
//   clk, rst               - clock; synchronous active-high reset
//   flush                  - drop the held entries and this cycle's input
//   in_valid/in_ready/in_data    - upstream side
//   out_valid/out_ready/out_data - downstream side; out_data = BUBBLE when empty
//   occupancy              - entries held (the state encoding itself)
//   stall_cnt              - saturating count of cycles with in_valid && !in_ready
// Handshake: a transfer happens on a side in any cycle where both valid and
// ready are high at the clock edge. A valid that has been raised stays raised
// with stable data until that transfer happens. Data leaves in FIFO order.
module pipeline_skid_stage
    import pipe_pkg::*;
#(
    parameter int               WIDTH  = 32,
    parameter bit               SKID   = 1'b1,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter int               CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_d, state_q;
    logic             in_ready_d, in_ready_q;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

    logic             main_load, main_clear, main_valid;
    logic [WIDTH-1:0] main_in, main_out;
    logic             skid_load, skid_clear;
    logic [WIDTH-1:0] skid_out;
    logic             accept, emit;

    pipe_entry_reg #(.WIDTH(WIDTH)) u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_in),
        .q     (main_out),
        .valid (main_valid)
    );

    generate
        if (SKID) begin : g_skid
            logic skid_valid_unused;
            pipe_entry_reg #(.WIDTH(WIDTH)) u_skid (
                .clk   (clk),
                .rst   (rst),
                .load  (skid_load),
                .clear (skid_clear),
                .d     (in_data),
                .q     (skid_out),
                .valid (skid_valid_unused)
            );
            // Registered ready: it can be known one cycle ahead, because the
            // skid entry absorbs the one beat that arrives while ready falls.
            assign in_ready = in_ready_q;
        end else begin : g_noskid
            logic unused_skid_ctrl;
            assign unused_skid_ctrl = ^{skid_load, skid_clear, in_ready_q};
            assign skid_out = BUBBLE;
            assign in_ready = !main_valid || out_ready;
        end
    endgenerate

    assign accept = in_valid && in_ready;
    assign emit   = main_valid && out_ready;

    // In the single-register mode, a FULL-state accept always comes with an
    // emit, so ST_SKID is unreachable and the skid controls go nowhere.
    always_comb begin
        state_d    = state_q;
        main_load  = 1'b0;
        main_clear = 1'b0;
        main_in    = in_data;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (flush) begin
            state_d    = ST_EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d   = ST_FULL;
                        main_load = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (accept && emit) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        state_d   = ST_SKID;
                        skid_load = 1'b1;
                    end else if (emit) begin
                        state_d    = ST_EMPTY;
                        main_clear = 1'b1;
                    end
                end
                ST_SKID: begin
                    if (emit) begin
                        state_d    = ST_FULL;
                        main_load  = 1'b1;
                        main_in    = skid_out;
                        skid_clear = 1'b1;
                    end
                end
                default: begin
                    state_d    = ST_EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
        in_ready_d = (state_d != ST_SKID);
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (in_valid && !in_ready && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid = main_valid;
    assign out_data  = main_valid ? main_out : BUBBLE;
    assign occupancy = state_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_skid_stage.sv
module tb_pipeline_skid_stage;

    localparam int W = 32;
    localparam logic [W-1:0] BUBBLE_B = 32'hBBBB_BBBB;

    int total = 0;
    int bad   = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // dut_a: SKID=1, CNT_W=16
    logic a_flush = 0, a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0;
    logic [W-1:0] a_in_data = '0, a_out_data;
    logic [1:0] a_occ;
    logic [15:0] a_stall;
    // dut_b: SKID=0, non-zero bubble
    logic b_flush = 0, b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0;
    logic [W-1:0] b_in_data = '0, b_out_data;
    logic [1:0] b_occ;
    logic [15:0] b_stall;
    // dut_c: SKID=1, CNT_W=3
    logic c_flush = 0, c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 0;
    logic [W-1:0] c_in_data = '0, c_out_data;
    logic [1:0] c_occ;
    logic [2:0] c_stall;

    pipeline_skid_stage #(.WIDTH(W), .SKID(1'b1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .occupancy(a_occ), .stall_cnt(a_stall)
    );

    pipeline_skid_stage #(.WIDTH(W), .SKID(1'b0), .BUBBLE(BUBBLE_B), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occupancy(b_occ), .stall_cnt(b_stall)
    );

    pipeline_skid_stage #(.WIDTH(W), .SKID(1'b1), .CNT_W(3)) dut_c (
        .clk(clk), .rst(rst), .flush(c_flush),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .occupancy(c_occ), .stall_cnt(c_stall)
    );

    // Scoreboards: inputs are stable mid-cycle, so handshakes are sampled on
    // the falling edge. Accepted data is pushed and emitted data is popped.
    logic [W-1:0] exp_a[$];
    logic [W-1:0] exp_b[$];

    always @(negedge clk) begin
        if (rst) begin
            exp_a.delete();
        end else begin
            if (a_out_valid && a_out_ready) begin
                total++;
                if (exp_a.size() == 0) begin
                    bad++;
                    $display("FAIL a_unexpected_out: got %h, expected nothing", a_out_data);
                end else if (a_out_data !== exp_a[0]) begin
                    bad++;
                    $display("FAIL a_out_order: got %h, expected %h", a_out_data, exp_a[0]);
                    void'(exp_a.pop_front());
                end else begin
                    void'(exp_a.pop_front());
                end
            end
            if (a_flush) exp_a.delete();
            else if (a_in_valid && a_in_ready) exp_a.push_back(a_in_data);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            exp_b.delete();
        end else begin
            if (b_out_valid && b_out_ready) begin
                total++;
                if (exp_b.size() == 0) begin
                    bad++;
                    $display("FAIL b_unexpected_out: got %h, expected nothing", b_out_data);
                end else if (b_out_data !== exp_b[0]) begin
                    bad++;
                    $display("FAIL b_out_order: got %h, expected %h", b_out_data, exp_b[0]);
                    void'(exp_b.pop_front());
                end else begin
                    void'(exp_b.pop_front());
                end
            end
            if (b_flush) exp_b.delete();
            else if (b_in_valid && b_in_ready) exp_b.push_back(b_in_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_in_valid = 1'b1;
        a_in_data = 32'hDEAD;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (a_out_valid !== 1'b0 || a_out_data !== 32'h0 || a_occ !== 2'd0 ||
                a_in_ready !== 1'b1 || a_stall !== 16'd0) begin
                bad++;
                $display("FAIL reset_a: valid=%b data=%h occ=%0d rdy=%b stall=%0d, expected 0/0/0/1/0",
                         a_out_valid, a_out_data, a_occ, a_in_ready, a_stall);
            end
            total++;
            if (b_out_valid !== 1'b0 || b_out_data !== BUBBLE_B || b_in_ready !== 1'b1 ||
                b_stall !== 16'd0 || c_stall !== 3'd0) begin
                bad++;
                $display("FAIL reset_b: valid=%b data=%h rdy=%b stall=%0d c_stall=%0d, expected 0/%h/1/0/0",
                         b_out_valid, b_out_data, b_in_ready, b_stall, c_stall, BUBBLE_B);
            end
        end
        rst = 1'b0;
        a_in_valid = 1'b0;
    endtask

    task automatic test_streaming();
        a_out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            a_in_valid = 1'b1;
            a_in_data = W'(i);
            total++;
            if (a_in_ready !== 1'b1) begin
                bad++;
                $display("FAIL stream_ready: got %b, expected 1 (beat %0d)", a_in_ready, i);
            end
            step();
            total++;
            if (a_out_valid !== 1'b1 || a_out_data !== W'(i) || a_occ > 2'd1) begin
                bad++;
                $display("FAIL stream_out: valid=%b data=%h occ=%0d, expected 1/%h/<=1",
                         a_out_valid, a_out_data, a_occ, W'(i));
            end
        end
        a_in_valid = 1'b0;
        step();
        total++;
        if (a_out_valid !== 1'b0 || a_occ !== 2'd0 || exp_a.size() != 0) begin
            bad++;
            $display("FAIL stream_drain: valid=%b occ=%0d pending=%0d, expected 0/0/0",
                     a_out_valid, a_occ, exp_a.size());
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] vals[3];
        logic         tab_ordy[6];
        logic         tab_irdy[6];
        logic [1:0]   tab_occ[6];
        logic [15:0]  tab_stall[6];
        int idx = 0;
        vals = '{32'd5, 32'd6, 32'd7};
        tab_ordy  = '{0, 0, 0, 0, 1, 1};
        tab_irdy  = '{1, 1, 0, 0, 0, 1};
        tab_occ   = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1};
        tab_stall = '{16'd0, 16'd0, 16'd1, 16'd2, 16'd3, 16'd3};
        for (int c = 0; c < 6; c++) begin
            logic took;
            a_out_ready = tab_ordy[c];
            a_in_valid = 1'b1;
            a_in_data = vals[idx];
            took = a_in_ready;
            total++;
            if (a_in_ready !== tab_irdy[c]) begin
                bad++;
                $display("FAIL bp_in_ready: cycle %0d got %b, expected %b", c, a_in_ready, tab_irdy[c]);
            end
            step();
            if (took && idx < 2) idx++;
            else if (took) idx = 3;
            total++;
            if (a_occ !== tab_occ[c] || a_stall !== tab_stall[c]) begin
                bad++;
                $display("FAIL bp_state: cycle %0d occ=%0d stall=%0d, expected %0d/%0d",
                         c, a_occ, a_stall, tab_occ[c], tab_stall[c]);
            end
            if (idx == 3) break;
        end
        a_in_valid = 1'b0;
        total++;
        if (idx != 3 || a_out_data !== 32'd7) begin
            bad++;
            $display("FAIL bp_last: accepted=%0d head=%h, expected 3/%h", idx, a_out_data, 32'd7);
        end
        step();
        total++;
        if (a_out_valid !== 1'b0 || a_occ !== 2'd0 || exp_a.size() != 0 || a_stall !== 16'd3) begin
            bad++;
            $display("FAIL bp_drain: valid=%b occ=%0d pending=%0d stall=%0d, expected 0/0/0/3",
                     a_out_valid, a_occ, exp_a.size(), a_stall);
        end
    endtask

    task automatic test_flush();
        a_out_ready = 1'b0;
        a_in_valid = 1'b1;
        a_in_data = 32'd8;
        step();
        a_in_data = 32'd9;
        step();
        total++;
        if (a_occ !== 2'd2 || a_out_data !== 32'd8) begin
            bad++;
            $display("FAIL flush_fill: occ=%0d head=%h, expected 2/%h", a_occ, a_out_data, 32'd8);
        end
        a_flush = 1'b1;
        a_in_data = 32'd10;
        step();
        a_flush = 1'b0;
        a_in_valid = 1'b0;
        total++;
        if (a_out_valid !== 1'b0 || a_out_data !== 32'h0 || a_occ !== 2'd0 ||
            a_in_ready !== 1'b1 || a_stall !== 16'd4) begin
            bad++;
            $display("FAIL flush_state: valid=%b data=%h occ=%0d rdy=%b stall=%0d, expected 0/0/0/1/4",
                     a_out_valid, a_out_data, a_occ, a_in_ready, a_stall);
        end
        a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (a_out_valid !== 1'b0) begin
                bad++;
                $display("FAIL flush_leak: out_valid=%b data=%h, expected 0", a_out_valid, a_out_data);
            end
        end
    endtask

    task automatic test_skid0();
        b_out_ready = 1'b0;
        b_in_valid = 1'b1;
        b_in_data = 32'd11;
        #1;
        total++;
        if (b_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL s0_empty_ready: got %b, expected 1", b_in_ready);
        end
        step();
        b_in_data = 32'd12;
        #1;
        total++;
        if (b_in_ready !== 1'b0 || b_occ !== 2'd1) begin
            bad++;
            $display("FAIL s0_full_ready: rdy=%b occ=%0d, expected 0/1", b_in_ready, b_occ);
        end
        step();
        total++;
        if (b_out_valid !== 1'b1 || b_out_data !== 32'd11 || b_stall !== 16'd1) begin
            bad++;
            $display("FAIL s0_hold: valid=%b data=%h stall=%0d, expected 1/%h/1",
                     b_out_valid, b_out_data, b_stall, 32'd11);
        end
        b_out_ready = 1'b1;
        #1;
        total++;
        if (b_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL s0_comb_ready: got %b, expected 1", b_in_ready);
        end
        step();
        total++;
        if (b_out_valid !== 1'b1 || b_out_data !== 32'd12) begin
            bad++;
            $display("FAIL s0_replace: valid=%b data=%h, expected 1/%h", b_out_valid, b_out_data, 32'd12);
        end
        b_in_data = 32'd13;
        step();
        total++;
        if (b_out_valid !== 1'b1 || b_out_data !== 32'd13) begin
            bad++;
            $display("FAIL s0_stream: valid=%b data=%h, expected 1/%h", b_out_valid, b_out_data, 32'd13);
        end
        b_in_valid = 1'b0;
        step();
        total++;
        if (b_out_valid !== 1'b0 || b_out_data !== BUBBLE_B || exp_b.size() != 0) begin
            bad++;
            $display("FAIL s0_drain: valid=%b data=%h pending=%0d, expected 0/%h/0",
                     b_out_valid, b_out_data, exp_b.size(), BUBBLE_B);
        end
    endtask

    task automatic test_saturation();
        int exp_cnt = 0;
        c_out_ready = 1'b0;
        c_in_valid = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            c_in_data = $urandom_range(255, 0);
            step();
            // The first two beats are taken; the next ten stall.
            if (k > 2 && exp_cnt < 7) exp_cnt++;
            total++;
            if (c_stall !== 3'(exp_cnt)) begin
                bad++;
                $display("FAIL sat_cnt: cycle %0d got %0d, expected %0d", k, c_stall, exp_cnt);
            end
        end
        c_in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_skid0();
        test_saturation();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
